// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Instruction-fetch front end for simple_cpu decode.
//                Issues sequential word-aligned fetch requests to a
//                variable-latency, in-order instruction memory. Returned
//                words are buffered with their PCs in a prefetch FIFO and
//                handed to decode over valid/ready. A redirect flushes the
//                FIFO and marks still-in-flight responses for discard.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: FETCH_ALIGN_CHECK_EN
//    defined   : adds output fetch_misalign. A misaligned redirect sets it
//                (sticky) and stops fetching until an aligned redirect or reset.
//    undefined : no fetch_misalign port; redirect_pc[1:0] is treated as 2'b00.
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   clock, rising edge
//    rstn             in   synchronous reset, active HIGH (legacy name)
//    redirect_valid   in   taken branch / jump this cycle
//    redirect_pc      in   new fetch address
//    imem_req_valid   out  fetch request valid
//    imem_req_ready   in   memory accepts request
//    imem_req_addr    out  fetch byte address (word aligned)
//    imem_resp_valid  in   in-order response word valid (always accepted)
//    imem_resp_data   in   fetched instruction
//    inst_valid       out  FIFO head valid
//    inst_ready       in   decode consumes head
//    inst_data        out  instruction at FIFO head
//    inst_pc          out  PC of instruction at FIFO head
//    fetch_misalign   out  (FETCH_ALIGN_CHECK_EN only) sticky misalign flag
// ============================================================================
module inst_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [DATA_WIDTH-1:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  fetch_misalign
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [CW:0]           c_depth      = (CW+1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] c_pc_step    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] c_align_mask = DATA_WIDTH'(3);

  // Fetch address and in-flight PC queue (PCs of requests awaiting response)
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_fl_pc [FIFO_DEPTH];
  logic [AW-1:0]         r_fl_rd;
  logic [AW-1:0]         r_fl_wr;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop;

  // Prefetch FIFO of {pc, inst}
  logic [DATA_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;

  logic [DATA_WIDTH-1:0] w_redirect_target;
  logic                  w_inhibit;
  logic                  w_credit;
  logic                  w_fire;
  logic                  w_resp;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_outstanding_nxt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_redirect_target = redirect_pc;
  assign w_inhibit         = r_misalign;
  assign fetch_misalign    = r_misalign;

  // Each redirect re-evaluates the flag, so only an aligned redirect clears it.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign w_redirect_target = redirect_pc & ~c_align_mask;
  assign w_inhibit         = 1'b0;
`endif

  // Credit: a request is only issued if a FIFO slot is reserved for its
  // response, counting both buffered words and words still in flight.
  assign w_credit       = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_depth;
  assign imem_req_valid = !rstn && !redirect_valid && !w_inhibit && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;
  assign w_resp         = imem_resp_valid;

  // A response is kept only when no stale responses remain to be discarded
  // and no redirect is flushing the pipe this cycle.
  assign w_push = w_resp && (r_drop == '0) && !redirect_valid;
  assign w_pop  = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = (r_count != '0);
  assign inst_data  = r_fifo_inst[r_rd_ptr];
  assign inst_pc    = r_fifo_pc[r_rd_ptr];

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_fire && !w_resp) begin
      w_outstanding_nxt = r_outstanding + 1'b1;
    end else if (!w_fire && w_resp && (r_outstanding != '0)) begin
      w_outstanding_nxt = r_outstanding - 1'b1;
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_fetch_pc    <= RESET_PC;
      r_fl_rd       <= '0;
      r_fl_wr       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      // In-flight queue tracks every request, kept or dropped, so it is
      // never flushed: stale entries retire as their responses arrive.
      if (w_fire) begin
        r_fl_wr    <= r_fl_wr + 1'b1;
        r_fetch_pc <= r_fetch_pc + c_pc_step;
      end
      if (w_resp) begin
        r_fl_rd <= r_fl_rd + 1'b1;
      end
      r_outstanding <= w_outstanding_nxt;

      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_target;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        // Everything still in flight is stale; a response landing in this
        // very cycle is already discarded, so it is not counted again.
        r_drop     <= w_resp ? (r_outstanding - 1'b1) : r_outstanding;
      end else begin
        if (w_resp && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  // Storage arrays: contents are qualified by the pointers/counters above,
  // so they need no reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_fl_pc[r_fl_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_fl_pc[r_fl_rd];
      r_fifo_inst[r_wr_ptr] <= imem_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Self-checking bench for inst_fetch_unit. A behavioural
//                in-order memory with configurable latency answers requests;
//                a scoreboard queue holds the expected {pc, inst} stream,
//                refilled whenever reset or a redirect is driven.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_fetch_unit;

  localparam int          DW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [DW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [DW-1:0] imem_resp_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [DW-1:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          fetch_misalign;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .DATA_WIDTH (DW),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          lat         = 1;
  int          fires       = 0;
  int          consumed    = 0;
  logic [31:0] exp_fetch;
  resp_t       pend[$];
  exp_t        sb[$];
  resp_t       mr;
  exp_t        me;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory image: any address maps to a distinct, easily recognisable word.
  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Expected delivery stream after reset/redirect: pc, pc+4, ... (wrapping).
  task automatic sb_restart(input logic [31:0] pc);
    exp_t e;
    sb.delete();
    for (int i = 0; i < 128; i++) begin
      e.pc   = pc + 32'(4 * i);
      e.data = img(e.pc);
      sb.push_back(e);
    end
    exp_fetch = pc;
  endtask

  // Memory model + monitor: sample at negedge, drive responses just after posedge.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (sb.size() == 0) begin
            check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
          end else begin
            me = sb.pop_front();
            check_eq("inst_pc", inst_pc, me.pc);
            check_eq("inst_data", inst_data, me.data);
          end
          consumed++;
        end
        if (redirect_valid) begin
          check_eq("req_in_redirect", 32'(imem_req_valid), 32'd0);
        end
        if (imem_req_valid && imem_req_ready) begin
          check_eq("req_addr", imem_req_addr, exp_fetch);
          check_eq("credit", 32'((pend.size() + int'(imem_resp_valid)) < DEPTH), 32'd1);
          exp_fetch = exp_fetch + 32'd4;
          mr.due  = cyc + lat;
          mr.data = img(imem_req_addr);
          pend.push_back(mr);
          fires++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic [31:0] exp_pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb_restart(exp_pc);
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int ok;
    rstn           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    sb_restart(RST_PC);

    // Reset state
    step(3);
    @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    step(1);
    rstn = 1'b0;

    // Zero-wait memory, decode always ready: one instruction per cycle.
    step(4);
    c0 = consumed;
    step(20);
    check_eq("throughput", 32'(consumed - c0), 32'd20);

    // Decode stall: FIFO fills to exactly DEPTH, requests stop.
    inst_ready = 1'b0;
    step(10);
    @(negedge clk);
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("stall_inst_valid", 32'(inst_valid), 32'd1);
    check_eq("stall_buffered", 32'(fires - consumed), 32'(DEPTH));
    step(1);
    inst_ready = 1'b1;
    step(10);

    // 3-cycle memory, 2 requests outstanding, then redirect to 0x40.
    imem_req_ready = 1'b0;
    step(6);
    lat            = 3;
    imem_req_ready = 1'b1;
    step(2);
    check_eq("two_outstanding", 32'(pend.size()), 32'd2);
    c0 = consumed;
    do_redirect(32'h40, 32'h40);
    step(14);
    check_eq("redir_progress", 32'(consumed - c0 >= 2), 32'd1);

    // Redirect coinciding with a response and a consume.
    lat = 1;
    step(6);
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      if (imem_resp_valid && inst_valid && inst_ready) ok = 1;
      else step(1);
    end
    check_eq("coincide_wait", 32'(ok), 32'd1);
    do_redirect(32'h100, 32'h100);
    @(negedge clk);
    check_eq("flush_empty", 32'(inst_valid), 32'd0);
    step(10);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    c0 = consumed;
    step(12);
    check_eq("wrap_progress", 32'(consumed - c0 >= 4), 32'd1);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect halts fetch until an aligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    sb.delete();
    exp_fetch      = 32'hFFFF_FFFF;
    step(1);
    redirect_valid = 1'b0;
    step(6);
    @(negedge clk);
    check_eq("misalign_set", 32'(fetch_misalign), 32'd1);
    check_eq("misalign_no_req", 32'(imem_req_valid), 32'd0);
    step(1);
    do_redirect(32'h80, 32'h80);
    @(negedge clk);
    check_eq("misalign_clr", 32'(fetch_misalign), 32'd0);
    step(10);
`else
    // Low address bits of a redirect are ignored.
    do_redirect(32'h202, 32'h200);
    step(10);
`endif

    // Reset with 3 requests outstanding; their responses land during reset.
    imem_req_ready = 1'b0;
    step(6);
    lat            = 3;
    imem_req_ready = 1'b1;
    step(3);
    check_eq("three_outstanding", 32'(pend.size() + int'(imem_resp_valid)), 32'd3);
    imem_req_ready = 1'b0;
    rstn           = 1'b1;
    step(6);
    @(negedge clk);
    check_eq("rst2_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    step(1);
    lat = 1;
    sb_restart(RST_PC);
    imem_req_ready = 1'b1;
    rstn           = 1'b0;
    c0 = consumed;
    step(12);
    check_eq("post_rst_progress", 32'(consumed - c0 >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of simple_cpu's decode logic; replaces the direct combinational read of inst_memory.
- Generates sequential fetch addresses and issues them to a variable-latency instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words with their PCs in a small prefetch FIFO and hands them to decode over a valid/ready interface.
- Handles PC redirects (branch/jump) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous, active-high reset. Name kept per codebase convention; asserted = 1'b1.
- redirect_valid  input  1  a taken branch or jump this cycle.
- redirect_pc  input  DATA_WIDTH  new fetch address.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  DATA_WIDTH  fetch address (byte address, word aligned).
- imem_resp_valid  input  1  response word valid. Responses are in order and always accepted; there is no ready signal.
- imem_resp_data  input  DATA_WIDTH  fetched instruction.
- inst_valid  output  1  FIFO head is valid.
- inst_ready  input  1  decode consumes the head.
- inst_data  output  DATA_WIDTH  instruction at the FIFO head.
- inst_pc  output  DATA_WIDTH  PC of the instruction at the FIFO head.

Behaviour:
- State: fetch_pc; in-flight PC queue (depth FIFO_DEPTH); prefetch FIFO of {pc, inst} with rd_ptr, wr_ptr and count; outstanding counter; drop counter.
- Reset, synchronous: fetch_pc = RESET_PC, FIFO empty, outstanding = 0, drop = 0, imem_req_valid = 0, inst_valid = 0. Reset asserted mid-transaction discards everything, including responses that arrive during reset.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + count < FIFO_DEPTH). This guarantees space for every accepted response.
- Request fire (valid && ready): push fetch_pc into the in-flight queue, fetch_pc += 4, outstanding += 1. fetch_pc wraps modulo 2^DATA_WIDTH.
- Response with drop == 0: pop the in-flight queue, push {pc, imem_resp_data} into the FIFO, outstanding -= 1.
- Response with drop > 0: discard the word, pop the in-flight queue, drop -= 1, outstanding -= 1.
- Consume (inst_valid && inst_ready): pop the FIFO head. inst_data and inst_pc come straight from the registered head; no combinational path from imem_resp to inst_*.
- Latency: request accepted at edge N and response at cycle N+k means inst_valid rises at edge N+k+1. The minimum request-to-decode latency is 2 cycles.
- Redirect, which has priority over all other events in the same cycle:
  - fetch_pc = redirect_pc.
  - FIFO cleared; a simultaneous consume is a don't-care, since decode is being flushed.
  - drop = outstanding minus 1 if a response arrives in the same cycle (that response is dropped).
  - No request is issued in the redirect cycle; requests resume the next cycle.
- Redirect while drop > 0 accumulates: drop is set from outstanding, so it is never lost.
- FIFO full (count == FIFO_DEPTH) implies no new requests; a push and a pop in the same cycle leave count unchanged.
- Boundary violations are bench assertions, not required RTL behaviour: outstanding never exceeds FIFO_DEPTH, and a response never arrives while outstanding == 0.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - redirect_pc[1:0] != 0 sets fetch_misalign, which is sticky, and inhibits all further requests.
  - Only an aligned redirect or reset clears fetch_misalign and resumes fetching.
- Undefined: the port is absent, and redirect_pc[1:0] is forced to 2'b00.

Test Plan:
- Reset, then a zero-wait memory with inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8, ..., one per cycle after 2-cycle startup; inst_data matches the memory image.
- inst_ready = 0 for 10 cycles -> exactly FIFO_DEPTH = 4 entries buffered, imem_req_valid = 0. Release -> PCs continue 0x0..0xC with no gap or duplicate.
- 3-cycle response latency with 2 requests outstanding, then redirect_pc = 0x40 -> both stale responses discarded, next inst_pc = 0x40, then 0x44.
- Redirect in the same cycle as a response and a consume -> the response is dropped and the FIFO is empty the next cycle. The first delivered PC is the redirect target.
- Reset asserted with 3 requests outstanding -> after deassert, late responses are ignored and the first inst_pc = RESET_PC.
- With FETCH_ALIGN_CHECK_EN, redirect_pc = 0x42 -> fetch_misalign = 1 and no requests. Then redirect_pc = 0x80 -> fetch_misalign = 0 and the first inst_pc = 0x80.
